// File: rtl/bram_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// bram_fill_ctrl_if
//   Groups the DMA read-data stream and the shared BRAM write bus seen by
//   bram_fill_ctrl.
//
//   Stream : vld/data (source -> controller), rdy (controller -> source).
//            A beat is accepted when vld & rdy.
//   BRAM   : bram_we (one bit per bank), bram_addr, bram_data (shared).
//
//   modport slave  : the fill controller (consumes stream, drives BRAM bus)
//   modport master : the environment (drives stream, observes BRAM bus)
// -----------------------------------------------------------------------------
interface bram_fill_ctrl_if #(
    parameter int BUF_NUM    = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
    logic                  rdy;
    logic [BUF_NUM-1:0]    bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;

    modport master (
        output vld, data,
        input  rdy, bram_we, bram_addr, bram_data
    );

    modport slave (
        input  vld, data,
        output rdy, bram_we, bram_addr, bram_data
    );
endinterface

// File: rtl/bram_fill_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fill_ctrl
//   Write-side fill controller for the CNN input/weight buffers. Scatters the
//   DMA read stream across BUF_NUM BRAM banks (interleaved per row, or
//   broadcast to every used bank), tracks buffer occupancy against a consumer
//   and throttles the DMA when no free buffer half remains.
//
//   Optional feature macro: BRAM_FILL_PINGPONG_EN
//     defined   : two halves per bank, address MSB selects the half being
//                 filled, word address is ADDR_WIDTH-1 bits, capacity 2.
//     undefined : single buffer, word address uses all ADDR_WIDTH bits,
//                 capacity 1, o_rd_half tied low.
//
// Ports
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_start           pulse, latches config and starts a job (IDLE only)
//   i_abort           synchronous abort to IDLE, clears occupancy/halves
//   i_bcast           config: write each word to all used banks
//   i_banks_used      config: banks per tile (0 or >BUF_NUM -> BUF_NUM)
//   i_row_words       config: words per bank per tile (0 -> 1)
//   i_total_words     config: beats in the job (0 -> immediate completion)
//   i_release         pulse, consumer frees the oldest full half
//   o_tile_done       pulse with the write of a tile's last word
//   o_rd_half         half the consumer must read next
//   o_busy            high from the cycle after i_start through o_done
//   o_done            pulse at job end
//   bus               stream in (vld/data/rdy) and BRAM write bus out
// -----------------------------------------------------------------------------
module bram_fill_ctrl #(
    parameter int BUF_NUM    = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TRANS_BITS = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_bcast,
    input  logic [5:0]            i_banks_used,
    input  logic [ADDR_WIDTH-1:0] i_row_words,
    input  logic [TRANS_BITS-1:0] i_total_words,
    input  logic                  i_release,
    output logic                  o_tile_done,
    output logic                  o_rd_half,
    output logic                  o_busy,
    output logic                  o_done,
    bram_fill_ctrl_if.slave       bus
);

`ifdef BRAM_FILL_PINGPONG_EN
    localparam int         WA_W = ADDR_WIDTH - 1;
    localparam logic [1:0] CAP  = 2'd2;
`else
    localparam int         WA_W = ADDR_WIDTH;
    localparam logic [1:0] CAP  = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, FILL, STALL, FLUSH} state_t;

    state_t                state;
    logic                  rdy_q;
    logic                  bcast;
    logic [5:0]            banks_m1;
    logic [WA_W-1:0]       row_m1;
    logic [TRANS_BITS-1:0] total;
    logic [WA_W-1:0]       word_cnt;
    logic [5:0]            bank_idx;
    logic [TRANS_BITS-1:0] beat_cnt;
    logic [1:0]            occ;
`ifdef BRAM_FILL_PINGPONG_EN
    logic                  fill_half;
    logic                  rd_half;
`endif

    logic                  acc, row_end, tile_last, last_beat, tile_end, rel;
    logic [1:0]            occ_nxt;
    logic [5:0]            banks_eff;
    logic [WA_W-1:0]       row_trunc;
    logic [BUF_NUM-1:0]    we_mask;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign bus.rdy = rdy_q;
`ifdef BRAM_FILL_PINGPONG_EN
    assign o_rd_half = rd_half;
    assign wr_addr   = {fill_half, word_cnt};
`else
    assign o_rd_half = 1'b0;
    assign wr_addr   = word_cnt;
`endif

    // Config sanitising: out-of-range bank counts mean "all banks"; row
    // length is taken modulo the word-address width, then 0 means 1.
    assign banks_eff = (i_banks_used == 6'd0 || int'(i_banks_used) > BUF_NUM)
                     ? 6'(BUF_NUM) : i_banks_used;
    assign row_trunc = i_row_words[WA_W-1:0];

    always_comb begin
        acc       = bus.vld & rdy_q;
        row_end   = (word_cnt == row_m1);
        tile_last = row_end & (bcast | (bank_idx == banks_m1));
        last_beat = ((beat_cnt + TRANS_BITS'(1)) == total);
        // The final beat of a job closes a tile even if it is partial.
        tile_end  = acc & (tile_last | last_beat);
        // A release that coincides with a tile end cancels it, even when no
        // half was full before, so occupancy is left untouched.
        rel       = i_release & ((occ != 2'd0) | tile_end);
        occ_nxt   = occ + {1'b0, tile_end} - {1'b0, rel};
    end

    always_comb begin
        we_mask = '0;
        for (int b = 0; b < BUF_NUM; b++)
            we_mask[b] = bcast ? (6'(b) <= banks_m1) : (6'(b) == bank_idx);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            rdy_q         <= 1'b0;
            bcast         <= 1'b0;
            banks_m1      <= '0;
            row_m1        <= '0;
            total         <= '0;
            word_cnt      <= '0;
            bank_idx      <= '0;
            beat_cnt      <= '0;
            occ           <= '0;
            bus.bram_we   <= '0;
            bus.bram_addr <= '0;
            bus.bram_data <= '0;
            o_tile_done   <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
`ifdef BRAM_FILL_PINGPONG_EN
            fill_half     <= 1'b0;
            rd_half       <= 1'b0;
`endif
        end else begin
            // Write stage: a beat accepted now lands in the bank next cycle,
            // including one accepted alongside i_abort.
            bus.bram_we <= acc ? we_mask : '0;
            if (acc) begin
                bus.bram_addr <= wr_addr;
                bus.bram_data <= bus.data;
            end
            o_tile_done <= tile_end & ~i_abort;
            o_done      <= 1'b0;

            if (i_abort) begin
                state    <= IDLE;
                rdy_q    <= 1'b0;
                o_busy   <= 1'b0;
                occ      <= '0;
                word_cnt <= '0;
                bank_idx <= '0;
                beat_cnt <= '0;
`ifdef BRAM_FILL_PINGPONG_EN
                fill_half <= 1'b0;
                rd_half   <= 1'b0;
`endif
            end else begin
                occ <= occ_nxt;
`ifdef BRAM_FILL_PINGPONG_EN
                if (rel)      rd_half   <= ~rd_half;
                if (tile_end) fill_half <= ~fill_half;
`endif
                if (acc) begin
                    beat_cnt <= beat_cnt + TRANS_BITS'(1);
                    if (row_end) begin
                        word_cnt <= '0;
                        bank_idx <= tile_last ? 6'd0 : bank_idx + 6'd1;
                    end else begin
                        word_cnt <= word_cnt + WA_W'(1);
                    end
                end

                case (state)
                    IDLE: begin
                        o_busy <= i_start;
                        if (i_start) begin
                            bcast    <= i_bcast;
                            banks_m1 <= banks_eff - 6'd1;
                            row_m1   <= (row_trunc == '0) ? '0 : row_trunc - WA_W'(1);
                            total    <= i_total_words;
                            word_cnt <= '0;
                            bank_idx <= '0;
                            beat_cnt <= '0;
                            // Occupancy survives jobs, so a new job may have
                            // to wait for the consumer before its first beat.
                            if (i_total_words == '0) begin
                                state <= FLUSH;
                                rdy_q <= 1'b0;
                            end else if (occ_nxt < CAP) begin
                                state <= FILL;
                                rdy_q <= 1'b1;
                            end else begin
                                state <= STALL;
                                rdy_q <= 1'b0;
                            end
                        end
                    end
                    FILL, STALL: begin
                        o_busy <= 1'b1;
                        if (acc && last_beat) begin
                            state <= FLUSH;
                            rdy_q <= 1'b0;
                        end else if (occ_nxt < CAP) begin
                            state <= FILL;
                            rdy_q <= 1'b1;
                        end else begin
                            state <= STALL;
                            rdy_q <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        state  <= IDLE;
                        rdy_q  <= 1'b0;
                        o_busy <= 1'b1;   // busy covers the o_done cycle
                        o_done <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        rdy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
